// File: rtl/unpooling_single_if.sv
// Valid/ready bundle for the max-unpool stage: pooled {value, argmax} in, full-resolution stream out.
interface unpooling_single_if #(
  parameter int unsigned data_width = 32,
  parameter int unsigned idx_width  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic [idx_width-1:0]  in_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_last;
  logic                  idx_err;

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last, idx_err
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last, idx_err
  );
endinterface

// File: rtl/unpooling_single.sv
// Streaming single-channel max-unpool: buffers one pooled row, then emits its P full-res rows,
// scattering each value to its argmax position and zero-filling the rest (plus REM tail rows).
module unpooling_single #(
  parameter int unsigned input_size   = 8,
  parameter int unsigned pooling_size = 2,
  parameter int unsigned data_width   = 32
) (
  input logic              clk,
  input logic              rst_n,
  unpooling_single_if.slave bus
);
  localparam int unsigned P        = pooling_size;
  localparam int unsigned PO       = input_size / P;
  localparam int unsigned REM      = input_size % P;
  localparam int unsigned IW       = (P * P > 1) ? $clog2(P * P) : 1;
  localparam int unsigned WCW      = (PO > 1) ? $clog2(PO) : 1;
  localparam int unsigned CW       = (input_size > 1) ? $clog2(input_size) : 1;
  localparam int unsigned RW       = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned REM_LAST = (REM > 0) ? REM - 1 : 0;
  localparam bit          HAS_TAIL = (REM > 0);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [WCW-1:0]        prow_q, prow_d;
  logic [CW-1:0]         c_q, c_d;
  logic [RW-1:0]         r_q, r_d;
  logic                  idx_err_q, idx_err_d;
  logic [data_width-1:0] buf_data_q [PO];
  logic [IW-1:0]         buf_idx_q  [PO];

  logic        in_fire, out_fire, c_last, r_last, band_last, frame_last;
  int unsigned col_w, win_pos;

  assign in_fire    = bus.in_valid && (state_q == LOAD);
  assign out_fire   = bus.out_ready && (state_q != LOAD);
  assign c_last     = (c_q == CW'(input_size - 1));
  assign r_last     = (state_q == TAIL) ? (r_q == RW'(REM_LAST)) : (r_q == RW'(P - 1));
  assign band_last  = c_last && r_last;
  assign frame_last = band_last && ((state_q == TAIL) ||
                      ((state_q == EMIT) && (prow_q == WCW'(PO - 1)) && !HAS_TAIL));
  assign bus.idx_err = idx_err_q;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      wcnt_q    <= '0;
      prow_q    <= '0;
      c_q       <= '0;
      r_q       <= '0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      prow_q    <= prow_d;
      c_q       <= c_d;
      r_q       <= r_d;
      idx_err_q <= idx_err_d;
    end
  end

  // Row buffer holds no reset: every entry is rewritten before the band that reads it
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_data_q[wcnt_q] <= bus.in_data;
      buf_idx_q[wcnt_q]  <= IW'(bus.in_idx);
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    prow_d    = prow_q;
    c_d       = c_q;
    r_d       = r_q;
    idx_err_d = idx_err_q | (in_fire && (32'(bus.in_idx) >= P * P));
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (wcnt_q == WCW'(PO - 1)) begin
            wcnt_d  = '0;
            state_d = EMIT;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      EMIT, TAIL: begin
        if (out_fire) begin
          if (c_last) begin
            c_d = '0;
            if (r_last) begin
              r_d = '0;
              if (state_q == TAIL) begin
                prow_d  = '0;
                state_d = LOAD;
              end else if (prow_q != WCW'(PO - 1)) begin
                prow_d  = prow_q + WCW'(1);
                state_d = LOAD;
              end else if (HAS_TAIL) begin
                state_d = TAIL;
              end else begin
                prow_d  = '0;
                state_d = LOAD;
              end
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Output decode from registered state, counters and buffer only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    col_w         = 32'(c_q) / P;
    win_pos       = 32'(r_q) * P + 32'(c_q) % P;
    case (state_q)
      LOAD: bus.in_ready = 1'b1;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = frame_last;
        if ((32'(c_q) < PO * P) && (32'(buf_idx_q[WCW'(col_w)]) == win_pos)) begin
          bus.out_data = buf_data_q[WCW'(col_w)];
        end
      end
      TAIL: begin
        bus.out_valid = 1'b1;
        bus.out_last  = frame_last;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_unpooling_single.sv
// Bench for unpooling_single: three instances (4x4/P2, 5x5/P2, 4x4/P3) checked against a scatter model.
module tb_unpooling_single;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [3];
  logic        in_valid  [3];
  logic [31:0] in_data   [3];
  logic [3:0]  in_idx    [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [31:0] out_data  [3];
  logic        out_last  [3];
  logic        idx_err   [3];

  unpooling_single_if #(.data_width(32), .idx_width(2)) if0 ();
  unpooling_single_if #(.data_width(32), .idx_width(2)) if1 ();
  unpooling_single_if #(.data_width(32), .idx_width(4)) if2 ();

  assign if0.in_valid = in_valid[0];  assign if0.in_data = in_data[0];
  assign if0.in_idx   = in_idx[0][1:0]; assign if0.out_ready = out_ready[0];
  assign in_ready[0]  = if0.in_ready;  assign out_valid[0] = if0.out_valid;
  assign out_data[0]  = if0.out_data;  assign out_last[0]  = if0.out_last;
  assign idx_err[0]   = if0.idx_err;

  assign if1.in_valid = in_valid[1];  assign if1.in_data = in_data[1];
  assign if1.in_idx   = in_idx[1][1:0]; assign if1.out_ready = out_ready[1];
  assign in_ready[1]  = if1.in_ready;  assign out_valid[1] = if1.out_valid;
  assign out_data[1]  = if1.out_data;  assign out_last[1]  = if1.out_last;
  assign idx_err[1]   = if1.idx_err;

  assign if2.in_valid = in_valid[2];  assign if2.in_data = in_data[2];
  assign if2.in_idx   = in_idx[2];    assign if2.out_ready = out_ready[2];
  assign in_ready[2]  = if2.in_ready;  assign out_valid[2] = if2.out_valid;
  assign out_data[2]  = if2.out_data;  assign out_last[2]  = if2.out_last;
  assign idx_err[2]   = if2.idx_err;

  unpooling_single #(.input_size(4), .pooling_size(2), .data_width(32))
    u_dut0 (.clk(clk), .rst_n(rst_n[0]), .bus(if0));
  unpooling_single #(.input_size(5), .pooling_size(2), .data_width(32))
    u_dut1 (.clk(clk), .rst_n(rst_n[1]), .bus(if1));
  unpooling_single #(.input_size(4), .pooling_size(3), .data_width(32))
    u_dut2 (.clk(clk), .rst_n(rst_n[2]), .bus(if2));

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          to_cnt, both_hi, held_bad;
  bit          tog;
  int          pv [16];
  int          pi [16];
  logic [31:0] obs_d [64];
  logic        obs_l [64];
  int          obs_n;
  int          expd [64];

  function automatic int sz(input int k);
    return (k == 1) ? 5 : 4;
  endfunction

  function automatic int ps(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  // Reference: zero map, then scatter each pooled value to its argmax pixel
  task automatic build_map(input int k);
    int s, p, po, y, x;
    s = sz(k); p = ps(k); po = s / p;
    for (int i = 0; i < 64; i++) expd[i] = 0;
    for (int w = 0; w < po * po; w++) begin
      if (pi[w] < p * p) begin
        y = (w / po) * p + pi[w] / p;
        x = (w % po) * p + pi[w] % p;
        expd[y * s + x] = pv[w];
      end
    end
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    in_data[k] = '0; in_idx[k] = '0;
    @(negedge clk); @(negedge clk);
    rst_n[k] = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge after the transfer
  task automatic send_val(input int k, input int d, input int i);
    int n = 0;
    in_valid[k] = 1'b1; in_data[k] = 32'(d); in_idx[k] = 4'(i);
    while (!in_ready[k] && n < 200) begin
      if (out_valid[k] && in_ready[k]) both_hi++;
      @(negedge clk); n++;
    end
    if (n >= 200) to_cnt++;
    else @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Pops one output element, optionally with alternating back-pressure; records hold violations
  task automatic pop_out(input int k, input bit stall, output logic [31:0] d, output logic l);
    int          n = 0;
    bit          pend = 1'b0;
    bit          done = 1'b0;
    logic [31:0] hd = '0;
    d = 'x; l = 1'bx;
    while (!done && n < 200) begin
      if (pend && out_data[k] !== hd) held_bad++;
      pend = 1'b0;
      if (in_ready[k] && out_valid[k]) both_hi++;
      out_ready[k] = stall ? tog : 1'b1;
      tog = ~tog;
      if (out_valid[k] && out_ready[k]) begin
        d = out_data[k]; l = out_last[k];
        @(posedge clk); @(negedge clk);
        out_ready[k] = 1'b0;
        done = 1'b1;
      end else begin
        if (out_valid[k]) begin pend = 1'b1; hd = out_data[k]; end
        @(negedge clk); n++;
      end
    end
    if (!done) to_cnt++;
  endtask

  task automatic stream_frame(input int k, input bit stall);
    int s, p, po, nout;
    s = sz(k); p = ps(k); po = s / p;
    obs_n = 0;
    for (int pr = 0; pr < po; pr++) begin
      for (int pc = 0; pc < po; pc++) send_val(k, pv[pr * po + pc], pi[pr * po + pc]);
      nout = p * s + ((pr == po - 1) ? (s % p) * s : 0);
      for (int j = 0; j < nout; j++) begin
        pop_out(k, stall, obs_d[obs_n], obs_l[obs_n]);
        obs_n++;
      end
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    for (int k = 0; k < 3; k++) do_reset(k);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_last[k] !== 1'b0 ||
          out_data[k] !== 32'd0 || idx_err[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b last=%b data=%0h err=%b, required 1 0 0 0 0",
                 k, in_ready[k], out_valid[k], out_last[k], out_data[k], idx_err[k]);
      end
    end
  endtask

  task automatic test_one_band;
    int          e1 [8];
    logic [31:0] d;
    logic        l;
    e1 = '{5, 0, 0, 0, 0, 0, 0, 7};
    do_reset(0); to_cnt = 0; both_hi = 0;
    send_val(0, 5, 0); send_val(0, 7, 3);
    tests_run++;
    if (out_valid[0] !== 1'b1) begin
      tests_failed++; $display("FAIL band_latency: out_valid=%b, required 1", out_valid[0]);
    end
    for (int j = 0; j < 8; j++) begin
      pop_out(0, 1'b0, d, l);
      tests_run++;
      if (d !== 32'(e1[j]) || l !== 1'b0) begin
        tests_failed++;
        $display("FAIL band_data[%0d]: got %0d last=%b, required %0d last=0", j, d, l, e1[j]);
      end
    end
    tests_run++;
    if (in_ready[0] !== 1'b1 || both_hi != 0 || to_cnt != 0) begin
      tests_failed++;
      $display("FAIL band_handshake: in_ready=%b overlap=%0d timeouts=%0d, required 1 0 0",
               in_ready[0], both_hi, to_cnt);
    end
    do_reset(0);
  endtask

  task automatic test_full_frame(input bit stall);
    int e2 [16];
    e2 = '{0, 1, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0, 4};
    pv[0] = 1; pi[0] = 1; pv[1] = 2; pi[1] = 2; pv[2] = 3; pi[2] = 0; pv[3] = 4; pi[3] = 3;
    do_reset(0); to_cnt = 0; both_hi = 0; held_bad = 0; tog = 1'b0;
    stream_frame(0, stall);
    for (int j = 0; j < 16; j++) begin
      tests_run++;
      if (obs_d[j] !== 32'(e2[j]) || obs_l[j] !== (j == 15)) begin
        tests_failed++;
        $display("FAIL frame_s%0d[%0d]: got %0d last=%b, required %0d last=%0d",
                 stall, j, obs_d[j], obs_l[j], e2[j], (j == 15));
      end
    end
    tests_run++;
    if (obs_n != 16 || to_cnt != 0 || both_hi != 0 || held_bad != 0) begin
      tests_failed++;
      $display("FAIL frame_s%0d_flow: n=%0d to=%0d overlap=%0d hold=%0d, required 16 0 0 0",
               stall, obs_n, to_cnt, both_hi, held_bad);
    end
  endtask

  task automatic test_tail;
    for (int w = 0; w < 4; w++) begin pv[w] = 9; pi[w] = 0; end
    build_map(1);
    to_cnt = 0; both_hi = 0;
    stream_frame(1, 1'b0);
    for (int j = 0; j < 25; j++) begin
      tests_run++;
      if (obs_d[j] !== 32'(expd[j]) || obs_l[j] !== (j == 24)) begin
        tests_failed++;
        $display("FAIL tail[%0d]: got %0d last=%b, required %0d last=%0d",
                 j, obs_d[j], obs_l[j], expd[j], (j == 24));
      end
    end
    tests_run++;
    if (obs_n != 25 || to_cnt != 0 || both_hi != 0 || in_ready[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL tail_flow: n=%0d to=%0d overlap=%0d rdy=%b, required 25 0 0 1",
               obs_n, to_cnt, both_hi, in_ready[1]);
    end
  endtask

  task automatic test_idx_err;
    do_reset(2); to_cnt = 0;
    pv[0] = 171; pi[0] = 9;
    send_val(2, pv[0], pi[0]);
    tests_run++;
    if (idx_err[2] !== 1'b1) begin
      tests_failed++; $display("FAIL idx_err_set: got %b, required 1", idx_err[2]);
    end
    for (int j = 0; j < 16; j++) begin
      pop_out(2, 1'b0, obs_d[j], obs_l[j]);
      tests_run++;
      if (obs_d[j] !== 32'd0 || obs_l[j] !== (j == 15)) begin
        tests_failed++;
        $display("FAIL idx_err_zero[%0d]: got %0d last=%b, required 0 last=%0d",
                 j, obs_d[j], obs_l[j], (j == 15));
      end
    end
    pv[0] = 6; pi[0] = 4;
    build_map(2);
    stream_frame(2, 1'b1);
    for (int j = 0; j < 16; j++) begin
      tests_run++;
      if (obs_d[j] !== 32'(expd[j])) begin
        tests_failed++;
        $display("FAIL p3_frame[%0d]: got %0d, required %0d", j, obs_d[j], expd[j]);
      end
    end
    tests_run++;
    if (idx_err[2] !== 1'b1 || to_cnt != 0) begin
      tests_failed++;
      $display("FAIL idx_err_sticky: err=%b to=%0d, required 1 0", idx_err[2], to_cnt);
    end
    do_reset(2);
    tests_run++;
    if (idx_err[2] !== 1'b0) begin
      tests_failed++; $display("FAIL idx_err_clear: got %b, required 0", idx_err[2]);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        l;
    pv[0] = 1; pi[0] = 1; pv[1] = 2; pi[1] = 2; pv[2] = 3; pi[2] = 0; pv[3] = 4; pi[3] = 3;
    do_reset(0); to_cnt = 0; both_hi = 0;
    send_val(0, pv[0], pi[0]); send_val(0, pv[1], pi[1]);
    for (int j = 0; j < 3; j++) pop_out(0, 1'b0, d, l);
    rst_n[0] = 1'b0;
    #1;
    tests_run++;
    if (out_valid[0] !== 1'b0 || out_last[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: vld=%b last=%b, required 0 0", out_valid[0], out_last[0]);
    end
    @(negedge clk); rst_n[0] = 1'b1; @(negedge clk);
    tests_run++;
    if (in_ready[0] !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset_ready: got %b, required 1", in_ready[0]);
    end
    build_map(0);
    stream_frame(0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      tests_run++;
      if (obs_d[j] !== 32'(expd[j]) || obs_l[j] !== (j == 15)) begin
        tests_failed++;
        $display("FAIL mid_reset_frame[%0d]: got %0d last=%b, required %0d last=%0d",
                 j, obs_d[j], obs_l[j], expd[j], (j == 15));
      end
    end
  endtask

  task automatic test_random;
    int s, p, po, n;
    for (int k = 0; k < 2; k++) begin
      s = sz(k); p = ps(k); po = s / p; n = s * s;
      for (int f = 0; f < 4; f++) begin
        for (int w = 0; w < po * po; w++) begin
          pv[w] = int'($urandom);
          pi[w] = int'($urandom_range(0, p * p - 1));
        end
        build_map(k);
        to_cnt = 0; both_hi = 0; held_bad = 0;
        stream_frame(k, 1'($urandom_range(0, 1)));
        for (int j = 0; j < n; j++) begin
          tests_run++;
          if (obs_d[j] !== 32'(expd[j]) || obs_l[j] !== (j == n - 1)) begin
            tests_failed++;
            $display("FAIL rand_k%0d_f%0d[%0d]: got %0h last=%b, required %0h last=%0d",
                     k, f, j, obs_d[j], obs_l[j], 32'(expd[j]), (j == n - 1));
          end
        end
        tests_run++;
        if (obs_n != n || to_cnt != 0 || both_hi != 0 || held_bad != 0) begin
          tests_failed++;
          $display("FAIL rand_k%0d_f%0d_flow: n=%0d to=%0d overlap=%0d hold=%0d, required %0d 0 0 0",
                   k, f, obs_n, to_cnt, both_hi, held_bad, n);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; in_idx[k] = '0; out_ready[k] = 1'b0;
    end
    tog = 1'b0; to_cnt = 0; both_hi = 0; held_bad = 0; obs_n = 0;
    test_reset();
    test_one_band();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_tail();
    test_idx_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
